wb_seg_scan_ctrl: RTL

//  Wishbone-slave, time-multiplexed hex 7-segment driver for 1..8 digits.

---
 rtl/wb_seg_scan_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/wb_seg_scan_ctrl.sv
// Wishbone-slave, time-multiplexed hex 7-segment scanner for 1..8 digits with inter-digit blanking.
// Optional build macro SEG_PWM_EN adds a 4-bit brightness register at word address 3.
module wb_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_HZ       = 100000000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  CYC_I,
  input  logic                  STB_I,
  input  logic                  WE_I,
  input  logic [1:0]            ADR_I,
  input  logic [3:0]            SEL_I,
  input  logic [31:0]           DAT_I,
  output logic [31:0]           DAT_O,
  output logic                  ACK_O,
  output logic [6:0]            O_cathode,
  output logic                  O_dp,
  output logic [NUM_DIGITS-1:0] O_anode
);

  localparam int DIV = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYCLES);
  localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);
  localparam logic          INV       = (ACTIVE_LOW != 0);

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic          blanking;

  logic [31:0] data_r;
  logic [7:0]  dig_en;
  logic [7:0]  dp_mask;
  logic        disp_en;

  logic        req;
  logic        wr;
  logic [31:0] rd_val;
  logic        pwm_on;

  // Handshake: a request is CYC_I & STB_I seen while ACK_O is low; the slave answers with a
  // one-cycle ACK_O on the next edge, which is also the edge that commits a write and registers
  // DAT_O. Dropping CYC_I or STB_I before that edge abandons the request with no side effects.
  assign req = CYC_I & STB_I & ~ACK_O;
  assign wr  = req & WE_I;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      presc <= '0;
      idx   <= 3'd0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign blanking = (presc < PRE_BLANK);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      data_r  <= 32'h0;
      dig_en  <= 8'hFF;
      dp_mask <= 8'h00;
      disp_en <= 1'b1;
    end else if (wr) begin
      case (ADR_I)
        2'd0: begin
          for (int i = 0; i < 4; i++) begin
            if (SEL_I[i]) data_r[8*i +: 8] <= DAT_I[8*i +: 8];
          end
        end
        2'd1: begin
          if (SEL_I[0]) dig_en  <= DAT_I[7:0];
          if (SEL_I[1]) dp_mask <= DAT_I[15:8];
          if (SEL_I[2]) disp_en <= DAT_I[16];
        end
        default: ;
      endcase
    end
  end

`ifdef SEG_PWM_EN
  logic [3:0] bright;
  logic [3:0] duty_cnt;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      bright   <= 4'hF;
      duty_cnt <= 4'h0;
    end else begin
      duty_cnt <= duty_cnt + 4'h1;
      if (wr && (ADR_I == 2'd3) && SEL_I[0]) bright <= DAT_I[3:0];
    end
  end

  assign pwm_on = (duty_cnt <= bright);
`else
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    rd_val = 32'h0;
    case (ADR_I)
      2'd0: rd_val = data_r;
      2'd1: rd_val = {15'h0, disp_en, dp_mask, dig_en};
      2'd2: rd_val = {28'h0, blanking, idx};
`ifdef SEG_PWM_EN
      2'd3: rd_val = {28'h0, bright};
`endif
      default: rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ACK_O <= 1'b0;
      DAT_O <= 32'h0;
    end else begin
      ACK_O <= req;
      DAT_O <= (req & ~WE_I) ? rd_val : 32'h0;
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'b1111110;
      4'h1: seg_decode = 7'b0110000;
      4'h2: seg_decode = 7'b1101101;
      4'h3: seg_decode = 7'b1111001;
      4'h4: seg_decode = 7'b0110011;
      4'h5: seg_decode = 7'b1011011;
      4'h6: seg_decode = 7'b1011111;
      4'h7: seg_decode = 7'b1110000;
      4'h8: seg_decode = 7'b1111111;
      4'h9: seg_decode = 7'b1111011;
      4'hA: seg_decode = 7'b1110111;
      4'hB: seg_decode = 7'b0011111;
      4'hC: seg_decode = 7'b1001110;
      4'hD: seg_decode = 7'b0111101;
      4'hE: seg_decode = 7'b1001111;
      default: seg_decode = 7'b1000111;
    endcase
  endfunction

  logic                  lit;
  logic [3:0]            nibble;
  logic [NUM_DIGITS-1:0] anode_h;
  logic [6:0]            cath_h;
  logic                  dp_h;

  // Pins are computed in active-high form and flipped once at the output register.
  always_comb begin
    nibble  = data_r[{idx, 2'b00} +: 4];
    lit     = disp_en & dig_en[idx] & ~blanking & pwm_on;
    anode_h = '0;
    cath_h  = 7'h00;
    dp_h    = 1'b0;
    if (lit) begin
      anode_h = NUM_DIGITS'(1) << idx;
      cath_h  = seg_decode(nibble);
      dp_h    = dp_mask[idx];
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      O_anode   <= {NUM_DIGITS{INV}};
      O_cathode <= {7{INV}};
      O_dp      <= INV;
    end else begin
      O_anode   <= anode_h ^ {NUM_DIGITS{INV}};
      O_cathode <= cath_h ^ {7{INV}};
      O_dp      <= dp_h ^ INV;
    end
  end

endmodule
